bp_be_cmd_queue_spec: RTL

//  Parametrised FE->BE command FIFO with speculative dequeue. Entries stay resident after dequeue until

---
 rtl/bp_be_cmd_queue_spec_if.sv | 35 +++
 rtl/bp_be_cmd_queue_spec.sv | 90 +++++++++
 2 files changed

// File: rtl/bp_be_cmd_queue_spec_if.sv
// FE->BE command port bundle: enqueue handshake, speculative dequeue, commit/rollback/flush controls
// and occupancy status.
interface bp_be_cmd_queue_spec_if #(
  parameter int width_p = 114,
  parameter int els_p   = 4
);
  localparam int ptr_w = $clog2(els_p) + 1;

  logic [width_p-1:0] fe_cmd_i;
  logic               fe_cmd_v_i;
  logic               fe_cmd_ready_o;
  logic [width_p-1:0] fe_cmd_o;
  logic               fe_cmd_v_o;
  logic               fe_cmd_yumi_i;
  logic               commit_i;
  logic               roll_back_i;
  logic               flush_i;
  logic [ptr_w-1:0]   count_o;
  logic [ptr_w-1:0]   spec_count_o;
  logic               empty_o;
  logic               full_o;
  logic               almost_full_o;

  modport master (
    output fe_cmd_i, fe_cmd_v_i, fe_cmd_yumi_i, commit_i, roll_back_i, flush_i,
    input  fe_cmd_ready_o, fe_cmd_o, fe_cmd_v_o, count_o, spec_count_o,
           empty_o, full_o, almost_full_o
  );

  modport slave (
    input  fe_cmd_i, fe_cmd_v_i, fe_cmd_yumi_i, commit_i, roll_back_i, flush_i,
    output fe_cmd_ready_o, fe_cmd_o, fe_cmd_v_o, count_o, spec_count_o,
           empty_o, full_o, almost_full_o
  );
endinterface

// File: rtl/bp_be_cmd_queue_spec.sv
// FE->BE command FIFO with speculative dequeue: entries stay resident until committed and the
// speculative read pointer can be rewound to the oldest uncommitted entry for replay.
module bp_be_cmd_queue_spec #(
  parameter int width_p           = 114,
  parameter int els_p             = 4,
  parameter int almost_full_thr_p = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bp_be_cmd_queue_spec_if.slave  cmd_if
);
  localparam int ptr_w = $clog2(els_p) + 1;
  localparam int idx_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];

  logic [ptr_w-1:0] wptr_reg, wptr_next;
  logic [ptr_w-1:0] rptr_spec_reg, rptr_spec_next;
  logic [ptr_w-1:0] rptr_cmt_reg, rptr_cmt_next;
  logic [ptr_w-1:0] count, spec_count;
  logic             full, enq;

  // Pointers carry one extra wrap bit, so plain subtraction gives occupancy modulo 2*els_p.
  assign count      = wptr_reg - rptr_cmt_reg;
  assign spec_count = rptr_spec_reg - rptr_cmt_reg;
  assign full       = (count == ptr_w'(els_p));
  assign enq        = cmd_if.fe_cmd_v_i & cmd_if.fe_cmd_ready_o;

  assign cmd_if.count_o        = count;
  assign cmd_if.spec_count_o   = spec_count;
  assign cmd_if.empty_o        = (count == '0);
  assign cmd_if.full_o         = full;
  assign cmd_if.almost_full_o  = (count >= ptr_w'(almost_full_thr_p));
  assign cmd_if.fe_cmd_v_o     = (wptr_reg != rptr_spec_reg);
  assign cmd_if.fe_cmd_ready_o = ~full & ~cmd_if.flush_i;
  assign cmd_if.fe_cmd_o       = mem[rptr_spec_reg[idx_w-1:0]];

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_spec_next = rptr_spec_reg;
    rptr_cmt_next  = rptr_cmt_reg;
    if (cmd_if.flush_i) begin
      wptr_next      = '0;
      rptr_spec_next = '0;
      rptr_cmt_next  = '0;
    end else begin
      rptr_cmt_next = rptr_cmt_reg + ptr_w'(cmd_if.commit_i);
      if (cmd_if.roll_back_i) begin
        // Replay restarts at whatever is still uncommitted after this cycle's commit.
        rptr_spec_next = rptr_cmt_next;
      end else begin
        rptr_spec_next = rptr_spec_reg + ptr_w'(cmd_if.fe_cmd_yumi_i);
      end
      wptr_next = wptr_reg + ptr_w'(enq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_reg      <= '0;
      rptr_spec_reg <= '0;
      rptr_cmt_reg  <= '0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_spec_reg <= rptr_spec_next;
      rptr_cmt_reg  <= rptr_cmt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr_reg[idx_w-1:0]] <= cmd_if.fe_cmd_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(cmd_if.fe_cmd_yumi_i && !cmd_if.fe_cmd_v_o))
        else $error("cmd_queue: yumi while no command valid");
      assert (!(cmd_if.commit_i && spec_count == '0))
        else $error("cmd_queue: commit with nothing dequeued");
      assert (!(cmd_if.roll_back_i && cmd_if.fe_cmd_yumi_i))
        else $error("cmd_queue: yumi together with roll_back");
      assert (spec_count <= count && count <= ptr_w'(els_p))
        else $error("cmd_queue: pointer ordering violated");
    end
  end
`endif
endmodule
